register_rename_file: RTL and testbench
=======================================

Name: register_rename_file

Overview:
- Architectural register file with per-register rename tags. It sits directly downstream of the reorder buffer's commit and rename outputs, and beside the decoder.
- It holds 32 x 32-bit integer registers. For each register it records whether a ROB entry will produce its next value, and which entry.
- It serves two combinational operand lookups for the decoder, forwarding through the ROB's value-query ports when the register is renamed.
- It drops all rename state on a pipeline flush.

Parameters:
ROB_WIDTH_BIT, 4, width of a ROB entry index (ROB holds 2^ROB_WIDTH_BIT entries)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-high reset
rdy_in  input  1  pause when low; no state update
clear  input  1  ROB flush pulse; discard all rename tags
set_reg_id  input  5  commit destination register (0 = no commit)
set_val  input  32  commit value
set_reg_on_rob_id  input  ROB_WIDTH_BIT  ROB entry being committed
set_dep_reg_id  input  5  register renamed by the instruction issued this cycle (0 = none)
set_dep_rob_id  input  ROB_WIDTH_BIT  ROB entry that will produce it
rs1_id  input  5  decoder operand-1 register
rs2_id  input  5  decoder operand-2 register
rs1_ready  output  1  operand-1 value available
rs1_val  output  32  operand-1 value (0 when not ready)
rs1_rob_id  output  ROB_WIDTH_BIT  producing ROB entry when not ready, else 0
rs2_ready  output  1  as rs1_ready, for operand 2
rs2_val  output  32  as rs1_val, for operand 2
rs2_rob_id  output  ROB_WIDTH_BIT  as rs1_rob_id, for operand 2
get_rob_id1  output  ROB_WIDTH_BIT  ROB query index for operand 1
rob_value1_ready  input  1  ROB query-1 result valid
rob_value1  input  32  ROB query-1 value
get_rob_id2  output  ROB_WIDTH_BIT  ROB query index for operand 2
rob_value2_ready  input  1  ROB query-2 result valid
rob_value2  input  32  ROB query-2 value

Behaviour:
- State per register r in 1..31: val[r] (32 bits), busy[r] (1 bit), tag[r] (ROB_WIDTH_BIT bits).
- Register x0 is never stored. It always reads val=0, ready=1, rob_id=0. Commits and renames targeting x0 are ignored; an id of 0 is the idle encoding from the ROB.
- Reset (rst_in=1 at a clock edge): all val=0, busy=0, tag=0. Reset has priority over clear and rdy_in. After reset, every read gives ready=1, val=0, rob_id=0.
- If rdy_in=0 and rst_in=0: no state changes. Outputs remain combinational from the current state.
- clear=1 (with rdy_in=1): every busy bit and tag is cleared. val is kept. Any commit or rename presented in the same cycle is ignored entirely, because those entries are flushed.
- Commit (set_reg_id=r≠0):
  - val[r] <= set_val, unconditionally.
  - busy[r] is cleared only if busy[r]=1, tag[r]==set_reg_on_rob_id, and no rename of r occurs in the same cycle.
  - If the tag does not match, a newer producer exists: the value is written and busy/tag are unchanged.
- Rename (set_dep_reg_id=r≠0): busy[r] <= 1, tag[r] <= set_dep_rob_id.
- Commit and rename to the same r in one cycle: the value is written and the rename wins for busy/tag.
- Commit and rename to different registers in one cycle are applied independently.
- Read ports are fully combinational and evaluated per operand k in {1,2}, with register r = rsk_id:
  - get_rob_idk = busy[r] ? tag[r] : 0.
  - If r==0 or !busy[r]: ready=1, val=val[r], rob_id=0.
  - If busy[r] and rob_valuek_ready: ready=1, val=rob_valuek, rob_id=0.
  - If busy[r] and !rob_valuek_ready: ready=0, val=0, rob_id=tag[r].
- Read ports reflect state before the current edge. Same-cycle commit values are still visible through the ROB query, because the committing entry is still ready in the ROB that cycle.
- A rename issued this cycle is not visible to reads until the next cycle. The decoder issues at most one instruction per cycle and reads its operands before its own rename.

Test Plan:
- Reset then read: assert rst_in, read rs1=5, rs2=0 -> both ready=1, val=0, rob_id=0.
- Rename then commit: rename x5 with tag 3, then commit x5 with 0xDEADBEEF and tag 3 -> next cycle x5 reads ready=1, val=0xDEADBEEF, get_rob_id1=0.
- Stale commit: rename x7 with tag 2, rename x7 with tag 6, commit x7 with 0x11 and tag 2 -> val[x7]=0x11, busy stays set, read gives rob_id=6 and ready=0 with rob_value1_ready=0; with rob_value1_ready=1 and rob_value1=0x22 -> ready=1, val=0x22.
- Same-cycle commit and rename on x9 (commit tag 1 with 0x55, rename tag 4) -> busy=1, tag=4, val=0x55.
- x0 protection: rename x0 with tag 5 and commit x0 with 0xFFFFFFFF -> x0 reads ready=1, val=0, rob_id=0.
- Flush: rename x3 with tag 1 and x4 with tag 2, commit x3 with 0x77 and tag 1, then pulse clear together with a rename of x8 and a commit of x4 -> x3 reads ready=1, val=0x77; x4 reads ready=1, val=0; x8 is not busy.
- rdy_in low: with rdy_in=0, a rename of x6 has no effect on later reads of x6.

Source files
------------

// File: rtl/register_rename_file.sv
// register_rename_file
//   Architectural integer register file (x1..x31, 32 bits each) with a
//   per-register rename tag naming the ROB entry that will produce the next
//   value. It sits downstream of the ROB commit/rename outputs and serves
//   two combinational operand lookups for the decoder. Renamed operands are
//   forwarded through the ROB value-query ports.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  state update enable (pause when low)
//   clear                   ROB flush: drop every rename tag, keep values
//   set_reg_id/set_val/
//   set_reg_on_rob_id       commit of a ROB entry into a register (id 0 = idle)
//   set_dep_reg_id/
//   set_dep_rob_id          rename of a register by the issuing instruction
//   rs{1,2}_id              decoder operand register ids
//   rs{1,2}_ready/val/rob_id operand lookup results
//   get_rob_id{1,2}         ROB query index for each operand
//   rob_value{1,2}_ready/
//   rob_value{1,2}          ROB query results
module register_rename_file #(
  parameter int ROB_WIDTH_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     clear,
  input  logic [4:0]               set_reg_id,
  input  logic [31:0]              set_val,
  input  logic [ROB_WIDTH_BIT-1:0] set_reg_on_rob_id,
  input  logic [4:0]               set_dep_reg_id,
  input  logic [ROB_WIDTH_BIT-1:0] set_dep_rob_id,
  input  logic [4:0]               rs1_id,
  input  logic [4:0]               rs2_id,
  output logic                     rs1_ready,
  output logic [31:0]              rs1_val,
  output logic [ROB_WIDTH_BIT-1:0] rs1_rob_id,
  output logic                     rs2_ready,
  output logic [31:0]              rs2_val,
  output logic [ROB_WIDTH_BIT-1:0] rs2_rob_id,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id1,
  input  logic                     rob_value1_ready,
  input  logic [31:0]              rob_value1,
  output logic [ROB_WIDTH_BIT-1:0] get_rob_id2,
  input  logic                     rob_value2_ready,
  input  logic [31:0]              rob_value2
);

  logic [31:0]              val_q  [32];
  logic [ROB_WIDTH_BIT-1:0] tag_q  [32];
  logic [31:0]              busy_q;

  logic commit_en;
  logic rename_en;
  logic commit_releases;

  assign commit_en = (set_reg_id != 5'd0);
  assign rename_en = (set_dep_reg_id != 5'd0);
  // A commit only frees the register if it comes from the newest producer
  // and the same register is not being renamed again this cycle.
  assign commit_releases = commit_en && busy_q[set_reg_id] &&
                           (tag_q[set_reg_id] == set_reg_on_rob_id) &&
                           !(rename_en && (set_dep_reg_id == set_reg_id));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else if (rdy_in) begin
      if (clear) begin
        // Flushed entries: any commit/rename this cycle is discarded too.
        busy_q <= '0;
        for (int i = 0; i < 32; i++) begin
          tag_q[i] <= '0;
        end
      end else begin
        if (commit_en) begin
          val_q[set_reg_id] <= set_val;
          if (commit_releases) begin
            busy_q[set_reg_id] <= 1'b0;
          end
        end
        if (rename_en) begin
          busy_q[set_dep_reg_id] <= 1'b1;
          tag_q[set_dep_reg_id]  <= set_dep_rob_id;
        end
      end
    end
  end

  // Operand 1 lookup
  logic busy1;
  assign busy1 = (rs1_id != 5'd0) && busy_q[rs1_id];

  always_comb begin
    get_rob_id1 = '0;
    rs1_ready   = 1'b1;
    rs1_val     = '0;
    rs1_rob_id  = '0;
    if (!busy1) begin
      if (rs1_id != 5'd0) rs1_val = val_q[rs1_id];
    end else begin
      get_rob_id1 = tag_q[rs1_id];
      if (rob_value1_ready) begin
        rs1_val = rob_value1;
      end else begin
        rs1_ready  = 1'b0;
        rs1_rob_id = tag_q[rs1_id];
      end
    end
  end

  // Operand 2 lookup
  logic busy2;
  assign busy2 = (rs2_id != 5'd0) && busy_q[rs2_id];

  always_comb begin
    get_rob_id2 = '0;
    rs2_ready   = 1'b1;
    rs2_val     = '0;
    rs2_rob_id  = '0;
    if (!busy2) begin
      if (rs2_id != 5'd0) rs2_val = val_q[rs2_id];
    end else begin
      get_rob_id2 = tag_q[rs2_id];
      if (rob_value2_ready) begin
        rs2_val = rob_value2;
      end else begin
        rs2_ready  = 1'b0;
        rs2_rob_id = tag_q[rs2_id];
      end
    end
  end

endmodule

// File: tb/tb_register_rename_file.sv
module tb_register_rename_file;
  localparam int W = 4;

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, clear;
  logic [4:0]   set_reg_id, set_dep_reg_id, rs1_id, rs2_id;
  logic [31:0]  set_val, rob_value1, rob_value2;
  logic [W-1:0] set_reg_on_rob_id, set_dep_rob_id;
  logic         rob_value1_ready, rob_value2_ready;
  logic         rs1_ready, rs2_ready;
  logic [31:0]  rs1_val, rs2_val;
  logic [W-1:0] rs1_rob_id, rs2_rob_id, get_rob_id1, get_rob_id2;

  register_rename_file #(.ROB_WIDTH_BIT(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .set_reg_id(set_reg_id), .set_val(set_val), .set_reg_on_rob_id(set_reg_on_rob_id),
    .set_dep_reg_id(set_dep_reg_id), .set_dep_rob_id(set_dep_rob_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_ready(rs1_ready), .rs1_val(rs1_val), .rs1_rob_id(rs1_rob_id),
    .rs2_ready(rs2_ready), .rs2_val(rs2_val), .rs2_rob_id(rs2_rob_id),
    .get_rob_id1(get_rob_id1), .rob_value1_ready(rob_value1_ready), .rob_value1(rob_value1),
    .get_rob_id2(get_rob_id2), .rob_value2_ready(rob_value2_ready), .rob_value2(rob_value2)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the architectural view of each register.
  logic [31:0]  m_val  [32];
  logic         m_busy [32];
  logic [W-1:0] m_tag  [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_read(input logic [4:0] r, input logic qr, input logic [31:0] qv,
                                     output logic rdy, output logic [31:0] v,
                                     output logic [W-1:0] rid, output logic [W-1:0] gid);
    logic renamed;
    renamed = (r != 0) && m_busy[r];
    gid = renamed ? m_tag[r] : '0;
    if (!renamed) begin
      rdy = 1'b1; v = (r == 0) ? 32'd0 : m_val[r]; rid = '0;
    end else if (qr) begin
      rdy = 1'b1; v = qv; rid = '0;
    end else begin
      rdy = 1'b0; v = 32'd0; rid = m_tag[r];
    end
  endfunction

  // Update the model from the inputs held across the clock edge.
  function automatic void model_step();
    if (rst_in) begin
      for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    end else if (rdy_in) begin
      if (clear) begin
        for (int i = 0; i < 32; i++) begin m_busy[i] = 0; m_tag[i] = 0; end
      end else begin
        if (set_reg_id != 0) begin
          m_val[set_reg_id] = set_val;
          if (m_busy[set_reg_id] && m_tag[set_reg_id] == set_reg_on_rob_id)
            m_busy[set_reg_id] = 0;
        end
        // Applied after the commit so a same-register rename takes precedence.
        if (set_dep_reg_id != 0) begin
          m_busy[set_dep_reg_id] = 1;
          m_tag[set_dep_reg_id]  = set_dep_rob_id;
        end
      end
    end
  endfunction

  task automatic drive(input logic rst, input logic rdy, input logic clr,
                       input logic [4:0] sreg, input logic [31:0] sval, input logic [W-1:0] srob,
                       input logic [4:0] dreg, input logic [W-1:0] drob,
                       input logic [4:0] r1, input logic [4:0] r2);
    rst_in = rst; rdy_in = rdy; clear = clr;
    set_reg_id = sreg; set_val = sval; set_reg_on_rob_id = srob;
    set_dep_reg_id = dreg; set_dep_rob_id = drob;
    rs1_id = r1; rs2_id = r2;
  endtask

  task automatic query(input logic q1r, input logic [31:0] q1v, input logic q2r, input logic [31:0] q2v);
    rob_value1_ready = q1r; rob_value1 = q1v;
    rob_value2_ready = q2r; rob_value2 = q2v;
  endtask

  task automatic check_outputs();
    logic rdy; logic [31:0] v; logic [W-1:0] rid, gid;
    #2;
    model_read(rs1_id, rob_value1_ready, rob_value1, rdy, v, rid, gid);
    chk("rs1_ready", rs1_ready, rdy);
    chk("rs1_val", rs1_val, v);
    chk("rs1_rob_id", rs1_rob_id, rid);
    chk("get_rob_id1", get_rob_id1, gid);
    model_read(rs2_id, rob_value2_ready, rob_value2, rdy, v, rid, gid);
    chk("rs2_ready", rs2_ready, rdy);
    chk("rs2_val", rs2_val, v);
    chk("rs2_rob_id", rs2_rob_id, rid);
    chk("get_rob_id2", get_rob_id2, gid);
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_busy[i] = 0; m_tag[i] = 0; end
    query(0, 0, 0, 0);

    // Reset then read
    drive(1, 1, 0, 0, 0, 0, 0, 0, 5, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 5, 0); check_outputs();
    chk("rst x5 ready", rs1_ready, 1); chk("rst x5 val", rs1_val, 0); chk("rst x5 rob", rs1_rob_id, 0);
    chk("rst x0 ready", rs2_ready, 1); chk("rst x0 val", rs2_val, 0); chk("rst x0 rob", rs2_rob_id, 0);
    tick();

    // Rename then commit
    drive(0, 1, 0, 0, 0, 0, 5, 3, 5, 0); check_outputs(); tick();
    drive(0, 1, 0, 5, 32'hDEADBEEF, 3, 0, 0, 5, 0);
    query(1, 32'hDEADBEEF, 0, 0); check_outputs();
    chk("x5 commit-cycle get", get_rob_id1, 3);
    tick();
    query(0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 0, 5, 0); check_outputs();
    chk("x5 ready", rs1_ready, 1); chk("x5 val", rs1_val, 32'hDEADBEEF); chk("x5 get", get_rob_id1, 0);
    tick();

    // Stale commit
    drive(0, 1, 0, 0, 0, 0, 7, 2, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 7, 6, 0, 0); tick();
    drive(0, 1, 0, 7, 32'h11, 2, 0, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 7, 0); check_outputs();
    chk("x7 stale ready", rs1_ready, 0); chk("x7 stale rob", rs1_rob_id, 6); chk("x7 stale get", get_rob_id1, 6);
    query(1, 32'h22, 0, 0); #1;
    chk("x7 fwd ready", rs1_ready, 1); chk("x7 fwd val", rs1_val, 32'h22);
    query(0, 0, 0, 0);
    tick();

    // Same-cycle commit and rename on x9
    drive(0, 1, 0, 9, 32'h55, 1, 9, 4, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 9, 9); check_outputs();
    chk("x9 ready", rs1_ready, 0); chk("x9 rob", rs1_rob_id, 4);
    tick();

    // x0 protection
    drive(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 0, 0); set_reg_id = 0;
    drive(0, 1, 0, 0, 32'hFFFFFFFF, 5, 0, 5, 0, 0); tick();
    drive(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 5, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); check_outputs();
    chk("x0 ready", rs1_ready, 1); chk("x0 val", rs1_val, 0); chk("x0 rob", rs1_rob_id, 0);
    tick();

    // Flush
    drive(0, 1, 0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 4, 2, 0, 0); tick();
    drive(0, 1, 0, 3, 32'h77, 1, 0, 0, 0, 0); tick();
    drive(0, 1, 1, 4, 32'h99, 2, 8, 3, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 3, 4); check_outputs();
    chk("flush x3 ready", rs1_ready, 1); chk("flush x3 val", rs1_val, 32'h77);
    chk("flush x4 ready", rs2_ready, 1); chk("flush x4 val", rs2_val, 0);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 8, 7); check_outputs();
    chk("flush x8 ready", rs1_ready, 1); chk("flush x8 get", get_rob_id1, 0);
    chk("flush x7 val", rs2_val, 32'h11);
    tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 9, 0); check_outputs();
    chk("flush x9 val", rs1_val, 32'h55);
    tick();

    // rdy_in low blocks a rename
    drive(0, 0, 0, 0, 0, 0, 6, 7, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 0, 6, 0); check_outputs();
    chk("paused x6 ready", rs1_ready, 1); chk("paused x6 get", get_rob_id1, 0);
    tick();

    // Randomized traffic, small register/tag ranges to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] sreg, dreg, r1, r2;
      logic [W-1:0] srob, drob;
      sreg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      dreg = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) begin sreg = 5'($urandom); dreg = 5'($urandom); end
      srob = W'($urandom_range(0, 3));
      drob = W'($urandom_range(0, 3));
      r1 = 5'($urandom_range(0, 8));
      r2 = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(0, 8));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0),
            sreg, $urandom, srob, dreg, drob, r1, r2);
      query($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom);
      check_outputs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
